// File: rtl/seq_div_nbit_pkg.sv
// Package shared by the sequential divider and its add/subtract stage.
//   state_e   : controller states (IDLE, RUN, DONE)
//   ADD / SUB : mode values for the add/subtract stage's k input
package seq_div_nbit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/seq_div_nbit_addsub.sv
// Combinational ripple add/subtract, N bits wide.
//   a_i, b_i : operands
//   k_i      : 0 = add, 1 = subtract (b is inverted and k feeds the carry-in)
//   s_o      : sum / difference
//   cout_o   : carry out of the MSB
module addsub_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         k_i,
    output logic [N-1:0] s_o,
    output logic         cout_o
);

    logic [N-1:0] b_x;
    logic [N:0]   c;

    assign b_x = b_i ^ {N{k_i}};

    always_comb begin
        c[0] = k_i;
        s_o  = '0;
        for (int i = 0; i < N; i++) begin
            s_o[i]  = a_i[i] ^ b_x[i] ^ c[i];
            c[i+1]  = (a_i[i] & b_x[i]) | (a_i[i] & c[i]) | (b_x[i] & c[i]);
        end
    end

    assign cout_o = c[N];

endmodule

// File: rtl/seq_div_nbit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   start_i             : request, accepted in IDLE or DONE only
//   dividend_i/divisor_i: operands, captured on acceptance
//   busy_o              : high while iterating (RUN)
//   done_o              : one-cycle pulse, results valid
//   quotient_o/remainder_o/div_by_zero_o : registered results, held until next done
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating, count_q bits left
// DONE  | results presented, done_o high for this cycle
module seq_div_nbit
    import seq_div_nbit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, done_q;

    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   trial;
    logic             unused_cout;
    logic             unused_a_msb;

    // A is always below M (< 2^WIDTH) between iterations, so its MSB is
    // zero and the shift only needs the low WIDTH bits.
    assign a_shift      = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign unused_a_msb = a_q[WIDTH];

    addsub_nbit #(.N(WIDTH + 1)) u_addsub (
        .a_i    (a_shift),
        .b_i    ({1'b0, m_q}),
        .k_i    (SUB),
        .s_o    (trial),
        .cout_o (unused_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            RUN: begin
                // Negative trial (MSB set) means restore: keep shifted A, quotient bit 0.
                a_d     = trial[WIDTH] ? a_shift : trial;
                q_d     = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = q_d;
                    rem_d   = a_d[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                if (start_i) begin
                    if (divisor_i == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        a_d     = '0;
                        q_d     = dividend_i;
                        m_d     = divisor_i;
                        count_d = CW'(WIDTH);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: doc/seq_div_nbit.md
Name: seq_div_nbit

Overview:
- Multi-cycle restoring divider (unsigned), the inverse-operation companion to the combinational 4-bit add/subtract datapath.
- Accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock using a shared add/sub stage in subtract mode (k=1, two's-complement via XOR + carry-in).
- Returns quotient and remainder with a one-cycle done pulse.
- Sits beside the arithmetic blocks as the sequential ALU divide unit.

Parameters:
- WIDTH, 4, operand / quotient / remainder width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on the rising edge of clk.
- dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
- divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
- busy  output  1  high while iterations are in progress (RUN state).
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  registered quotient; holds until the next done.
- remainder  output  WIDTH  registered remainder; holds until the next done.
- div_by_zero  output  1  registered flag, updated with each done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal A, Q, M and count all cleared.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE.
  - start while in RUN is ignored, with no effect on the operation in flight.
- Accept with divisor != 0:
  - A=0 (WIDTH+1 bits), Q=dividend, M=divisor, count=WIDTH.
  - Next state RUN; busy=1.
- Accept with divisor == 0:
  - Next state DONE directly; busy stays 0.
  - Result registers: quotient = all ones, remainder = dividend, div_by_zero=1.
- RUN iteration, one per clock:
  - Shift {A,Q} left by 1.
  - trial = A_shifted - {0,M}, computed by the add/sub sub-module in subtract mode at WIDTH+1 bits.
  - If the trial MSB is 0: A=trial, Q[0]=1. Else: A unchanged (restore), Q[0]=0.
  - count decrements.
  - On the iteration where count==1: next state DONE; quotient=Q_new, remainder=A_new[WIDTH-1:0], div_by_zero=0; busy falls.
- DONE: done=1 for exactly this one cycle. Next state is IDLE, or RUN/DONE if start is accepted in the same cycle (back-to-back operation).
- Latency:
  - Nonzero divisor: done is high in the cycle following the WIDTH-th rising edge after the accepting edge (WIDTH+1 edges total including the accept).
  - Zero divisor: done is high in the cycle after the accepting edge.
- Output timing: done, busy, quotient, remainder and div_by_zero are all registered; there are no combinational paths from inputs to outputs.
- Boundary cases:
  - dividend < divisor gives quotient 0, remainder = dividend.
  - dividend == divisor gives quotient 1, remainder 0.
  - divisor=1 gives quotient = dividend.
  - Inputs changing during RUN do not affect the result (operands are captured at accept).
- Reset mid-RUN aborts immediately to the reset values. No done is produced for the aborted operation.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Mode constants for the add/sub stage: ADD=1'b0, SUB=1'b1.
- One sub-module: addsub_nbit, a combinational parameterised (WIDTH+1) ripple add/subtract.
  - Inputs: a, b, k. Outputs: s, cout.
  - Internal structure: XOR b with k, with k as carry-in.
  - Instantiated once with k tied to SUB.
- count width: $clog2(WIDTH+1).

Test Plan:
- WIDTH=4, 13/3: pulse start -> busy for 4 cycles; then done=1 for one cycle, quotient=4, remainder=1, div_by_zero=0.
- Edge values, back-to-back starts: 15/15 -> q=1, r=0. 7/9 -> q=0, r=7. 15/1 -> q=15, r=0. Assert start again in each DONE cycle -> no idle gap, each result is correct.
- Divide by zero, 9/0 -> done one cycle after accept, busy never high, q=4'b1111, r=9, div_by_zero=1. A following 8/2 -> q=4, r=0, div_by_zero=0.
- Start while busy: start 14/4, then pulse start with 1/1 two cycles later -> second start ignored; done once with q=3, r=2.
- Inputs changing during RUN: start 12/5, change dividend/divisor every cycle during RUN -> q=2, r=2.
- Reset mid-RUN: deassert rst_n during the 2nd iteration -> all outputs 0 immediately, no done. After release, 10/3 -> q=3, r=1.
- Exhaustive sweep, all 256 pairs at WIDTH=4 -> compare against a reference model: dividend/divisor and dividend%divisor, with the divisor-0 rule above.
